dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised, byte-addressed data memory with a request/ready handshake, MIPS sub-word access (byte/half/word), load sign/zero extension, misalignment error reporting and configurable access latency. It sits at the MEM stage of the pipelined CPU, replacing the flat word-only data RAM. The stall unit holds the pipeline while `busy` is high.

## Interface
Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words; power of two.
- ADDR_W, 14, byte-address width; must equal clog2(DEPTH_WORDS)+2.
- LATENCY, 1, edges from request acceptance to access completion; must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  access request; sampled only when state is IDLE or DONE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- ready  out  1  one-cycle completion pulse.
- rdata  out  32  load result; valid while ready=1.
- err  out  1  misaligned or reserved-size access; valid while ready=1.
- busy  out  1  high while an accepted access is in flight (state WAIT).

## Operation
- States: IDLE, WAIT, DONE. Accept condition: state ∈ {IDLE, DONE} and req=1. On accept, latch addr, size, we, wdata and sign_ext.
- Alignment check at accept:
  - size=01 requires addr[0]=0.
  - size=10 requires addr[1:0]=00.
  - size=11 is always an error.
- Error at accept: next state DONE with ready=1, err=1, rdata=0. No memory write. LATENCY is not applied.
- Valid access at accept: next state WAIT, counter = LATENCY-1.
- WAIT with counter>0: decrement the counter.
- WAIT with counter=0: perform the access and go to DONE with ready=1, err=0.
- DONE: accept a new request if req=1, otherwise go to IDLE. ready is low in every state except DONE.
- Word index = addr[ADDR_W-1:2]. Lanes are little-endian: byte k = bits [8k+7:8k].
- Stores:
  - Byte: write wdata[7:0] to lane addr[1:0].
  - Half: write wdata[15:0] to lanes {2·addr[1]+1, 2·addr[1]}.
  - Word: write all four lanes.
  - Unselected lanes keep their contents.
- Loads:
  - Extract the selected lane(s) and extend to 32 bits per sign_ext. Word loads ignore sign_ext.
  - Stores return rdata=0.
- Memory contents are zero at time zero and are not cleared by rst.
- Out-of-range addresses cannot occur because of the ADDR_W rule.

## Timing
- Reset values: state=IDLE, counter=0, ready=0, err=0, rdata=0, busy=0.
- Valid access accepted at edge E0: memory update and rdata capture happen at edge E0+LATENCY, and ready is high for the cycle following that edge.
- Back-to-back period: LATENCY+1 cycles when req is held in DONE.
- Error access: ready/err high for the cycle after accept edge E0.
- busy=1 exactly while in WAIT. req and its operands are ignored during WAIT.
- Load following a store to the same word returns the updated data. There is no forwarding hazard, because the store completes before DONE.
- rst asserted mid-WAIT: access aborted, no write, all outputs return to reset values immediately. The memory write occurs only at the completing edge.
- rdata and err hold their values only while ready=1. They are cleared to 0 on leaving DONE.

## Test plan
- Reset/idle: assert rst mid-sim → ready=0, err=0, rdata=0, busy=0 immediately; earlier stored data is still readable after release.
- Word store/load, LATENCY=1: store 0xDEADBEEF @0x10, then load word @0x10 → ready one cycle after completion edge, rdata=0xDEADBEEF, err=0; busy high for exactly 1 cycle per access.
- Sub-word store: word @0x20=0x11223344, then sb 0xAA @0x22 → word reads 0x11AA3344.
  - sh 0xBEEF @0x20 → word reads 0x11AABEEF.
- Sub-word load extension, word @0x30=0x80FF7F01:
  - lb signed @0x32 → 0xFFFFFFFF.
  - lbu @0x33 → 0x00000080.
  - lh signed @0x32 → 0xFFFF80FF.
  - lhu @0x30 → 0x00007F01.
- Errors:
  - Half @0x41 → err=1, rdata=0, ready in the next cycle, memory unchanged.
  - Word @0x42 → err=1.
  - size=11 @0x40 → err=1.
- LATENCY=3 with reset abort: req held high for store-load pairs gives a 4-cycle period. rst asserted during WAIT of a store of 0x12345678 @0x50 → subsequent load @0x50 returns the old value 0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressed data memory with req/ready handshake, sub-word access,
// load extension, misalignment reporting and configurable access latency.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = 14,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         size_q;
  logic               we_q;
  logic               sign_ext_q;
  logic [31:0]        wdata_q;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               misaligned;
  logic               complete;
  logic [ADDR_W-3:0]  widx;
  logic [3:0]         lane_en;
  logic [31:0]        wlanes;
  logic [31:0]        rword;
  logic [31:0]        rshift;
  logic [31:0]        load_val;

  assign misaligned = (size == 2'b11) ||
                      (size == 2'b01 && addr[0]) ||
                      (size == 2'b10 && addr[1:0] != 2'b00);

  assign complete = (state == WAIT) && (cnt == '0);
  assign widx     = addr_q[ADDR_W-1:2];
  assign rword    = mem[widx];
  assign rshift   = rword >> {addr_q[1:0], 3'b000};

  // Replicate the store data across lanes so each enabled lane picks its own slice.
  always_comb begin
    lane_en = 4'b0000;
    wlanes  = wdata_q;
    case (size_q)
      2'b00: begin
        lane_en[addr_q[1:0]] = 1'b1;
        wlanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_en[{addr_q[1], 1'b0}] = 1'b1;
        lane_en[{addr_q[1], 1'b1}] = 1'b1;
        wlanes = {2{wdata_q[15:0]}};
      end
      default: lane_en = 4'b1111;
    endcase
  end

  always_comb begin
    load_val = rword;
    case (size_q)
      2'b00:   load_val = {{24{sign_ext_q & rshift[7]}}, rshift[7:0]};
      2'b01:   load_val = {{16{sign_ext_q & rshift[15]}}, rshift[15:0]};
      default: load_val = rword;
    endcase
  end

  // Memory is never reset; a reset landing on the completing edge aborts the write.
  always_ff @(posedge clk) begin
    if (complete && we_q && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem[widx][8*k +: 8] <= wlanes[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ready      <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      addr_q     <= '0;
      size_q     <= 2'b00;
      we_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      wdata_q    <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      busy  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (req) begin
            addr_q     <= addr;
            size_q     <= size;
            we_q       <= we;
            sign_ext_q <= sign_ext;
            wdata_q    <= wdata;
            if (misaligned) begin
              state <= DONE;
              ready <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY - 1);
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
            busy <= 1'b1;
          end else begin
            state <= DONE;
            ready <= 1'b1;
            rdata <= we_q ? 32'd0 : load_val;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl with LATENCY=1 and LATENCY=3 instances.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        sel;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [13:0] addr;
  logic [31:0] wdata;

  logic        req1, ready1, err1, busy1;
  logic        req3, ready3, err3, busy3;
  logic [31:0] rdata1, rdata3;
  logic        ready, err, busy;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;
  logic [32:0] sb [$];

  always #5 clk = ~clk;

  assign req1  = req & ~sel;
  assign req3  = req & sel;
  assign ready = sel ? ready3 : ready1;
  assign err   = sel ? err3   : err1;
  assign busy  = sel ? busy3  : busy1;
  assign rdata = sel ? rdata3 : rdata1;

  dmem_ctrl #(.DEPTH_WORDS(4096), .ADDR_W(14), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready1), .rdata(rdata1), .err(err1), .busy(busy1)
  );

  dmem_ctrl #(.DEPTH_WORDS(4096), .ADDR_W(14), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(ready3), .rdata(rdata3), .err(err3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic s, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [13:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    int k;
    int bcnt;
    int lat;
    logic [32:0] e;
    lat = s ? 3 : 1;
    sb.push_back({exp_err, exp_rdata});
    @(negedge clk);
    sel = s; req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    k = 1;
    bcnt = 0;
    while (!ready && k < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_rdata"}, rdata, e[31:0]);
    chk({tag, "_err"}, 32'(err), 32'(e[32]));
    chk({tag, "_lat"}, k, exp_err ? 32'd1 : 32'(lat + 1));
    chk({tag, "_busy"}, bcnt, exp_err ? 32'd0 : 32'(lat));
  endtask

  initial begin
    int k;
    int t;
    logic [32:0] e;
    rst = 1'b1; req = 1'b0; sel = 1'b0; we = 1'b0; size = 2'b10; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready1 | ready3), 32'd0);
    chk("rst_err", 32'(err1 | err3), 32'd0);
    chk("rst_busy", 32'(busy1 | busy3), 32'd0);
    chk("rst_rdata", rdata1 | rdata3, 32'd0);
    rst = 1'b0;

    access(0, 1, 2'b10, 0, 14'h010, 32'hDEADBEEF, 32'h0, 0, "sw10");
    access(0, 0, 2'b10, 0, 14'h010, 32'h0, 32'hDEADBEEF, 0, "lw10");

    access(0, 1, 2'b10, 0, 14'h020, 32'h11223344, 32'h0, 0, "sw20");
    access(0, 1, 2'b00, 0, 14'h022, 32'h555555AA, 32'h0, 0, "sb22");
    access(0, 0, 2'b10, 0, 14'h020, 32'h0, 32'h11AA3344, 0, "lw20a");
    access(0, 1, 2'b01, 0, 14'h020, 32'h7777BEEF, 32'h0, 0, "sh20");
    access(0, 0, 2'b10, 1, 14'h020, 32'h0, 32'h11AABEEF, 0, "lw20b");

    access(0, 1, 2'b10, 0, 14'h030, 32'h80FF7F01, 32'h0, 0, "sw30");
    access(0, 0, 2'b00, 1, 14'h032, 32'h0, 32'hFFFFFFFF, 0, "lb32");
    access(0, 0, 2'b00, 0, 14'h033, 32'h0, 32'h00000080, 0, "lbu33");
    access(0, 0, 2'b00, 0, 14'h032, 32'h0, 32'h000000FF, 0, "lbu32");
    access(0, 0, 2'b00, 1, 14'h030, 32'h0, 32'h00000001, 0, "lb30");
    access(0, 0, 2'b01, 1, 14'h032, 32'h0, 32'hFFFF80FF, 0, "lh32");
    access(0, 0, 2'b01, 0, 14'h030, 32'h0, 32'h00007F01, 0, "lhu30");

    access(0, 1, 2'b10, 0, 14'h040, 32'h55667788, 32'h0, 0, "sw40");
    access(0, 1, 2'b01, 0, 14'h041, 32'hFFFFFFFF, 32'h0, 1, "sh41err");
    access(0, 1, 2'b10, 0, 14'h042, 32'hFFFFFFFF, 32'h0, 1, "sw42err");
    access(0, 1, 2'b11, 0, 14'h040, 32'hFFFFFFFF, 32'h0, 1, "sz11err");
    access(0, 0, 2'b01, 1, 14'h043, 32'h0, 32'h0, 1, "lh43err");
    access(0, 0, 2'b10, 0, 14'h040, 32'h0, 32'h55667788, 0, "lw40");

    access(1, 1, 2'b10, 0, 14'h050, 32'h00000000, 32'h0, 0, "l3sw50");
    access(1, 0, 2'b10, 0, 14'h050, 32'h0, 32'h00000000, 0, "l3lw50a");

    // req held through DONE: store then load of the same word, one access per 4 cycles
    sb.push_back({1'b0, 32'h0});
    sb.push_back({1'b0, 32'hCAFEF00D});
    @(negedge clk);
    sel = 1'b1; req = 1'b1; we = 1'b1; size = 2'b10; addr = 14'h058; wdata = 32'hCAFEF00D;
    k = 0;
    do begin @(negedge clk); k++; end while (!ready && k < 20);
    e = sb.pop_front();
    chk("b2b_st_lat", k, 32'd4);
    chk("b2b_st_rdata", rdata, e[31:0]);
    we = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!ready && t < 20);
    req = 1'b0;
    e = sb.pop_front();
    chk("b2b_period", t, 32'd4);
    chk("b2b_ld_rdata", rdata, e[31:0]);
    chk("b2b_ld_err", 32'(err), 32'(e[32]));

    // reset during WAIT of a store must drop the write
    @(negedge clk);
    sel = 1'b1; req = 1'b1; we = 1'b1; size = 2'b10; addr = 14'h050; wdata = 32'h12345678;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 32'(busy3), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy3), 32'd0);
    chk("abort_ready", 32'(ready3), 32'd0);
    chk("abort_err", 32'(err3), 32'd0);
    chk("abort_rdata", rdata3, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    access(1, 0, 2'b10, 0, 14'h050, 32'h0, 32'h00000000, 0, "l3lw50b");
    access(1, 0, 2'b10, 0, 14'h058, 32'h0, 32'hCAFEF00D, 0, "l3lw58");

    access(0, 0, 2'b10, 0, 14'h010, 32'h0, 32'hDEADBEEF, 0, "lw10post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
